mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 121 ++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Two-port (cpu / program loader) arbiter in front of a single synchronous RAM.
// Define ARB_ROUND_ROBIN_EN for round-robin on simultaneous requests; default is loader-priority.
module mem_arbiter #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  input  logic              ld_req,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  output logic              ld_ack,
  output logic [DATA_W-1:0] rd_data,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              gnt_id
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

  state_e            state_q;
  logic              cpu_ack_q;
  logic              ld_ack_q;
  logic              mem_en_q;
  logic              mem_we_q;
  logic              txn_we_q;
  logic              gnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rd_data_q;
  logic              win_d;

`ifdef ARB_ROUND_ROBIN_EN
  // Last port granted; the other port wins a tie. Reset value 0 (cpu) lets the loader go first.
  logic rr_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      rr_q <= 1'b0;
    end else if (state_q == IDLE && (cpu_req || ld_req)) begin
      rr_q <= win_d;
    end
  end

  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch can be inferred.
    win_d = ld_req;
    if (cpu_req && ld_req) win_d = ~rr_q;
  end
`else
  always_comb begin
    win_d = ld_req;
  end
`endif

  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    if (reset) begin
      state_q   <= IDLE;
      cpu_ack_q <= 1'b0;
      ld_ack_q  <= 1'b0;
      mem_en_q  <= 1'b0;
      mem_we_q  <= 1'b0;
      txn_we_q  <= 1'b0;
      gnt_q     <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rd_data_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cpu_req || ld_req) begin
            state_q  <= ACCESS;
            gnt_q    <= win_d;
            mem_en_q <= 1'b1;
            mem_we_q <= win_d ? ld_we : cpu_we;
            txn_we_q <= win_d ? ld_we : cpu_we;
            addr_q   <= win_d ? ld_addr : cpu_addr;
            wdata_q  <= win_d ? ld_wdata : cpu_wdata;
          end
        end
        ACCESS: begin
          state_q   <= RESP;
          mem_en_q  <= 1'b0;
          mem_we_q  <= 1'b0;
          cpu_ack_q <= ~gnt_q;
          ld_ack_q  <= gnt_q;
        end
        RESP: begin
          state_q   <= IDLE;
          cpu_ack_q <= 1'b0;
          ld_ack_q  <= 1'b0;
          if (!txn_we_q) rd_data_q <= mem_rdata;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cpu_ack   = cpu_ack_q;
  assign ld_ack    = ld_ack_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign gnt_id    = gnt_q;

  // The RAM only returns data in the ack cycle, so a read passes mem_rdata straight
  // through during RESP; rd_data_q holds it afterwards and is untouched by writes.
  assign rd_data = (state_q == RESP && !txn_we_q) ? mem_rdata : rd_data_q;

endmodule
